// File: rtl/sram_rd_arbiter.sv
// Round-robin read arbiter sharing one fixed-latency SRAM read port among N_REQ requesters.
// Optional macro SRAM_RD_ARB_PRIO0_EN gives requester 0 absolute priority over the others.
//
// state  | meaning
// S_IDLE | no access in flight; arbitrate and issue the read strobe
// S_WAIT | read issued; count down the SRAM latency
// S_ACK  | ack_o pulse to the winner; no new grant this cycle
module sram_rd_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        busy_o,
    output logic [ADDR_WIDTH-1:0]       sram_addr_o,
    output logic                        sram_re_o,
    input  logic [DATA_WIDTH-1:0]       sram_data_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   grant_idx;
    logic            grant_vld;

    // Descending scan so the last hit is the first requester after the pointer.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
`ifdef SRAM_RD_ARB_PRIO0_EN
        for (int i = N_REQ - 1; i >= 1; i--) begin
            if (req_i[1 + (int'(rr_ptr) - 1 + i) % (N_REQ - 1)]) begin
                grant_idx = IW'(1 + (int'(rr_ptr) - 1 + i) % (N_REQ - 1));
                grant_vld = 1'b1;
            end
        end
        if (req_i[0]) begin
            grant_idx = '0;
            grant_vld = 1'b1;
        end
`else
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_i[(int'(rr_ptr) + i) % N_REQ]) begin
                grant_idx = IW'((int'(rr_ptr) + i) % N_REQ);
                grant_vld = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o       <= '0;
            data_o      <= '0;
            sram_addr_o <= '0;
            sram_re_o   <= 1'b0;
            rr_ptr      <= IW'(N_REQ - 1);
            winner_q    <= '0;
            cnt_q       <= '0;
        end else begin
            sram_re_o <= 1'b0;
            ack_o     <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        sram_addr_o <= addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        sram_re_o   <= 1'b1;
                        winner_q    <= grant_idx;
                        cnt_q       <= CW'(RD_LATENCY);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        data_o          <= sram_data_i;
                        ack_o[winner_q] <= 1'b1;
`ifdef SRAM_RD_ARB_PRIO0_EN
                        // Requester 0 grants leave the shared rotation untouched.
                        if (winner_q != '0) rr_ptr <= winner_q;
`else
                        rr_ptr <= winner_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
